// File: rtl/id_decode_pipe.sv
// RV32IM decode stage with registered ID/EX output, prioritised bypass, load-use stall and flush.
// Define ID_CUSTOM_EXT_EN to decode the custom-0 opcode (SID/RT/IF); otherwise custom-0 is illegal.
module id_decode_pipe #(
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           inst_i,
  input  logic [31:0]           inst_addr_i,
  input  logic                  prdt_taken_i,
  output logic [4:0]            reg1_raddr_o,
  output logic [4:0]            reg2_raddr_o,
  input  logic [31:0]           rf_reg1_rdata_i,
  input  logic [31:0]           rf_reg2_rdata_i,
  output logic [31:0]           csr_raddr_o,
  input  logic [31:0]           csr_rdata_i,
  input  logic [NUM_FWD-1:0]    fwd_valid_i,
  input  logic [5*NUM_FWD-1:0]  fwd_waddr_i,
  input  logic [32*NUM_FWD-1:0] fwd_wdata_i,
  input  logic                  ex_load_pending_i,
  input  logic [4:0]            ex_load_waddr_i,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [31:0]           inst_o,
  output logic [31:0]           inst_addr_o,
  output logic                  prdt_taken_o,
  output logic [31:0]           op1_o,
  output logic [31:0]           op2_o,
  output logic [31:0]           op1_jump_o,
  output logic [31:0]           op2_jump_o,
  output logic [31:0]           reg1_rdata_o,
  output logic [31:0]           reg2_rdata_o,
  output logic                  reg_we_o,
  output logic [4:0]            reg_waddr_o,
  output logic                  csr_we_o,
  output logic [31:0]           csr_waddr_o,
  output logic [31:0]           csr_rdata_o,
  output logic                  illegal_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_FENCE  = 7'b0001111;
  localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] NOP       = 32'h0000_0001;
`ifdef ID_CUSTOM_EXT_EN
  localparam logic [6:0]  OP_CUST0  = 7'b0001011;
  localparam logic [2:0]  F3_SID    = 3'b000;
  localparam logic [2:0]  F3_RT     = 3'b001;
  localparam logic [2:0]  F3_IF     = 3'b010;
`endif

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic        use1, use2;
  logic [31:0] src1, src2;
  logic        hazard, capture, stall;

  logic        d_illegal, d_reg_we, d_csr_we;
  logic [4:0]  d_reg_waddr;
  logic [31:0] d_op1, d_op2, d_op1_jump, d_op2_jump;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign rs1    = inst_i[19:15];
  assign rd     = inst_i[11:7];
  assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b  = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_j  = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_u  = {inst_i[31:12], 12'h000};

  // custom IF with a zero immediate takes its second operand from x31
  always_comb begin
    rs2 = inst_i[24:20];
`ifdef ID_CUSTOM_EXT_EN
    if (opcode == OP_CUST0 && funct3 == F3_IF && inst_i[31:20] == 12'h000) rs2 = 5'd31;
`endif
  end

  assign reg1_raddr_o = rs1;
  assign reg2_raddr_o = rs2;
  assign csr_raddr_o  = {20'h00000, inst_i[31:20]};

  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    case (opcode)
      OP_REG, OP_BRANCH, OP_STORE: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: use1 = 1'b1;
      OP_SYSTEM: use1 = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b011);
`ifdef ID_CUSTOM_EXT_EN
      OP_CUST0: begin
        use1 = (funct3 == F3_SID) || (funct3 == F3_IF);
        use2 = (funct3 == F3_IF) && (imm_i == 32'h0);
      end
`endif
      default: ;
    endcase
  end

  // walk channels lowest priority first so channel 0 wins
  always_comb begin
    src1 = rf_reg1_rdata_i;
    src2 = rf_reg2_rdata_i;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid_i[i] && fwd_waddr_i[5*i +: 5] == rs1) src1 = fwd_wdata_i[32*i +: 32];
      if (fwd_valid_i[i] && fwd_waddr_i[5*i +: 5] == rs2) src2 = fwd_wdata_i[32*i +: 32];
    end
    if (rs1 == 5'd0 || !use1) src1 = '0;
    if (rs2 == 5'd0 || !use2) src2 = '0;
  end

  always_comb begin
    d_illegal   = 1'b0;
    d_reg_we    = 1'b0;
    d_reg_waddr = '0;
    d_csr_we    = 1'b0;
    d_op1       = '0;
    d_op2       = '0;
    d_op1_jump  = '0;
    d_op2_jump  = '0;
    case (opcode)
      OP_IMM: begin
        if ((funct3 == 3'b001 && funct7 != 7'h00) ||
            (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)) begin
          d_illegal = 1'b1;
        end else begin
          d_reg_we    = 1'b1;
          d_reg_waddr = rd;
          d_op1       = src1;
          d_op2       = imm_i;
        end
      end
      OP_REG: begin
        if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          d_reg_we    = 1'b1;
          d_reg_waddr = rd;
          d_op1       = src1;
          d_op2       = src2;
        end else if (funct7 == 7'h01) begin
          d_reg_waddr = rd;
          d_op1       = src1;
          d_op2       = src2;
          // DIV/REM retire later from the divider, which needs the return pc
          if (funct3[2]) begin
            d_op1_jump = inst_addr_i;
            d_op2_jump = 32'd4;
          end else begin
            d_reg_we = 1'b1;
          end
        end else begin
          d_illegal = 1'b1;
        end
      end
      OP_LOAD: begin
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
          d_illegal = 1'b1;
        end else begin
          d_reg_we    = 1'b1;
          d_reg_waddr = rd;
          d_op1       = src1;
          d_op2       = imm_i;
        end
      end
      OP_STORE: begin
        if (funct3[2] || funct3 == 3'b011) begin
          d_illegal = 1'b1;
        end else begin
          d_op1 = src1;
          d_op2 = imm_s;
        end
      end
      OP_BRANCH: begin
        if (funct3 == 3'b010 || funct3 == 3'b011) begin
          d_illegal = 1'b1;
        end else begin
          d_op1      = src1;
          d_op2      = src2;
          d_op1_jump = inst_addr_i;
          d_op2_jump = inst_i[31] ? 32'd4 : imm_b;
        end
      end
      OP_JAL: begin
        d_reg_we    = 1'b1;
        d_reg_waddr = rd;
        d_op1       = inst_addr_i;
        d_op2       = 32'd4;
        d_op1_jump  = inst_addr_i;
        d_op2_jump  = imm_j;
      end
      OP_JALR: begin
        if (funct3 != 3'b000) begin
          d_illegal = 1'b1;
        end else begin
          d_reg_we    = 1'b1;
          d_reg_waddr = rd;
          d_op1       = inst_addr_i;
          d_op2       = 32'd4;
          d_op1_jump  = src1;
          d_op2_jump  = imm_i;
        end
      end
      OP_LUI: begin
        d_reg_we    = 1'b1;
        d_reg_waddr = rd;
        d_op1       = imm_u;
      end
      OP_AUIPC: begin
        d_reg_we    = 1'b1;
        d_reg_waddr = rd;
        d_op1       = inst_addr_i;
        d_op2       = imm_u;
      end
      OP_FENCE: begin
        d_op1_jump = inst_addr_i;
        d_op2_jump = 32'd4;
      end
      OP_SYSTEM: begin
        if (funct3 == 3'b100) begin
          d_illegal = 1'b1;
        end else if (funct3 != 3'b000) begin
          d_reg_we    = 1'b1;
          d_reg_waddr = rd;
          d_csr_we    = 1'b1;
        end
      end
`ifdef ID_CUSTOM_EXT_EN
      OP_CUST0: begin
        case (funct3)
          F3_SID: d_op1 = 32'h3000_0000;
          F3_RT: begin
            d_reg_we    = 1'b1;
            d_reg_waddr = rd;
            d_op1       = 32'h7003_0000;
          end
          F3_IF: begin
            d_reg_we    = 1'b1;
            d_reg_waddr = rd;
            d_op1       = src1;
            d_op2       = (imm_i != 32'h0) ? imm_i : src2;
          end
          default: d_illegal = 1'b1;
        endcase
      end
`endif
      default: d_illegal = 1'b1;
    endcase
  end

  assign hazard = in_valid_i && ex_load_pending_i && (ex_load_waddr_i != 5'd0) &&
                  ((use1 && rs1 == ex_load_waddr_i) || (use2 && rs2 == ex_load_waddr_i));
  assign in_ready_o = flush_i | ((~out_valid_o | out_ready_i) & ~hazard);
  assign capture    = in_valid_i & in_ready_o & ~flush_i;
  assign stall      = hazard & (~out_valid_o | out_ready_i) & ~flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o  <= 1'b0;
      inst_o       <= NOP;
      inst_addr_o  <= '0;
      prdt_taken_o <= 1'b0;
      op1_o        <= '0;
      op2_o        <= '0;
      op1_jump_o   <= '0;
      op2_jump_o   <= '0;
      reg1_rdata_o <= '0;
      reg2_rdata_o <= '0;
      reg_we_o     <= 1'b0;
      reg_waddr_o  <= '0;
      csr_we_o     <= 1'b0;
      csr_waddr_o  <= '0;
      csr_rdata_o  <= '0;
      illegal_o    <= 1'b0;
      stall_cnt_o  <= '0;
    end else begin
      if (flush_i) begin
        out_valid_o <= 1'b0;
      end else if (capture) begin
        out_valid_o  <= 1'b1;
        inst_o       <= inst_i;
        inst_addr_o  <= inst_addr_i;
        prdt_taken_o <= prdt_taken_i;
        op1_o        <= d_op1;
        op2_o        <= d_op2;
        op1_jump_o   <= d_op1_jump;
        op2_jump_o   <= d_op2_jump;
        reg1_rdata_o <= src1;
        reg2_rdata_o <= src2;
        reg_we_o     <= d_reg_we;
        reg_waddr_o  <= d_reg_waddr;
        csr_we_o     <= d_csr_we;
        csr_waddr_o  <= d_csr_we ? csr_raddr_o : 32'h0;
        csr_rdata_o  <= csr_rdata_i;
        illegal_o    <= d_illegal;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
      if (stall && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_decode_pipe.sv
// Directed bench for id_decode_pipe: expected ID/EX entries are queued at drive time and
// checked when the entry leaves the stage. Follows ID_CUSTOM_EXT_EN for the custom-0 check.
module tb_id_decode_pipe;
  localparam int NF = 2;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, in_valid_i, in_ready_o, prdt_taken_i;
  logic [31:0]    inst_i, inst_addr_i;
  logic [4:0]     reg1_raddr_o, reg2_raddr_o;
  logic [31:0]    rf_reg1_rdata_i, rf_reg2_rdata_i, csr_raddr_o, csr_rdata_i;
  logic [NF-1:0]  fwd_valid_i;
  logic [5*NF-1:0]  fwd_waddr_i;
  logic [32*NF-1:0] fwd_wdata_i;
  logic           ex_load_pending_i, flush_i, out_valid_o, out_ready_i;
  logic [4:0]     ex_load_waddr_i, reg_waddr_o;
  logic [31:0]    inst_o, inst_addr_o, op1_o, op2_o, op1_jump_o, op2_jump_o;
  logic [31:0]    reg1_rdata_o, reg2_rdata_o, csr_waddr_o, csr_rdata_o;
  logic           prdt_taken_o, reg_we_o, csr_we_o, illegal_o;
  logic [CW-1:0]  stall_cnt_o;

  logic [31:0] rf [32];
  assign rf_reg1_rdata_i = rf[reg1_raddr_o];
  assign rf_reg2_rdata_i = rf[reg2_raddr_o];
  assign csr_rdata_i     = 32'hC5C5_0000 | csr_raddr_o;

  id_decode_pipe #(.NUM_FWD(NF), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .prdt_taken_i(prdt_taken_i),
    .reg1_raddr_o(reg1_raddr_o), .reg2_raddr_o(reg2_raddr_o),
    .rf_reg1_rdata_i(rf_reg1_rdata_i), .rf_reg2_rdata_i(rf_reg2_rdata_i),
    .csr_raddr_o(csr_raddr_o), .csr_rdata_i(csr_rdata_i),
    .fwd_valid_i(fwd_valid_i), .fwd_waddr_i(fwd_waddr_i), .fwd_wdata_i(fwd_wdata_i),
    .ex_load_pending_i(ex_load_pending_i), .ex_load_waddr_i(ex_load_waddr_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .prdt_taken_o(prdt_taken_o),
    .op1_o(op1_o), .op2_o(op2_o), .op1_jump_o(op1_jump_o), .op2_jump_o(op2_jump_o),
    .reg1_rdata_o(reg1_rdata_o), .reg2_rdata_o(reg2_rdata_o),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_rdata_o(csr_rdata_o),
    .illegal_o(illegal_o), .stall_cnt_o(stall_cnt_o)
  );

  typedef struct {
    logic [31:0] inst, pc, op1, op2, op1j, op2j, r1, r2, cwa, crd;
    logic        prdt, we, ill, cwe;
    logic [4:0]  wa;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic exp_t mk(input logic [31:0] inst, input logic [31:0] pc, input logic prdt,
                              input logic [31:0] op1, input logic [31:0] op2,
                              input logic [31:0] op1j, input logic [31:0] op2j,
                              input logic [31:0] r1, input logic [31:0] r2,
                              input logic we, input logic [4:0] wa, input logic ill,
                              input logic cwe, input logic [31:0] cwa);
    exp_t e;
    e.inst = inst; e.pc = pc; e.prdt = prdt; e.op1 = op1; e.op2 = op2;
    e.op1j = op1j; e.op2j = op2j; e.r1 = r1; e.r2 = r2; e.we = we; e.wa = wa;
    e.ill = ill; e.cwe = cwe; e.cwa = cwa;
    e.crd = 32'hC5C5_0000 | {20'h0, inst[31:20]};
    return e;
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d,
                                        input logic [6:0] op);
    return {imm, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3,
                                        input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3);
    return {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    n_vec++;
    assert (q.size() > 0) else begin
      n_err++;
      $error("FAIL sb_underflow: observed entry inst %h expected no entry", inst_o);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("inst", inst_o, e.inst);
      chk("inst_addr", inst_addr_o, e.pc);
      chk("prdt_taken", {31'h0, prdt_taken_o}, {31'h0, e.prdt});
      chk("op1", op1_o, e.op1);
      chk("op2", op2_o, e.op2);
      chk("op1_jump", op1_jump_o, e.op1j);
      chk("op2_jump", op2_jump_o, e.op2j);
      chk("reg1_rdata", reg1_rdata_o, e.r1);
      chk("reg2_rdata", reg2_rdata_o, e.r2);
      chk("reg_we", {31'h0, reg_we_o}, {31'h0, e.we});
      chk("reg_waddr", {27'h0, reg_waddr_o}, {27'h0, e.wa});
      chk("illegal", {31'h0, illegal_o}, {31'h0, e.ill});
      chk("csr_we", {31'h0, csr_we_o}, {31'h0, e.cwe});
      chk("csr_waddr", csr_waddr_o, e.cwa);
      chk("csr_rdata", csr_rdata_o, e.crd);
    end
  endtask

  // entries leave the stage on the edge after this negedge sample
  task automatic tick();
    @(negedge clk);
    if (out_valid_o === 1'b1 && out_ready_i === 1'b1) pop_check();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic prdt);
    in_valid_i = 1'b1;
    inst_i = inst;
    inst_addr_i = pc;
    prdt_taken_i = prdt;
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic prdt, input exp_t e);
    drive(inst, pc, prdt);
    q.push_back(e);
    tick();
  endtask

  logic [31:0] ins, lui_i;

  initial begin
    rst = 1'b1; in_valid_i = 1'b0; inst_i = '0; inst_addr_i = '0; prdt_taken_i = 1'b0;
    fwd_valid_i = '0; fwd_waddr_i = '0; fwd_wdata_i = '0;
    ex_load_pending_i = 1'b0; ex_load_waddr_i = '0; flush_i = 1'b0; out_ready_i = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'h0; rf[2] = 32'd7; rf[31] = 32'd9;
    tick();
    tick();
    rst = 1'b0;
    out_ready_i = 1'b1;
    #1;
    chk("rst_out_valid", {31'h0, out_valid_o}, 32'h0);
    chk("rst_inst", inst_o, 32'h1);
    chk("rst_op1", op1_o, 32'h0);
    chk("rst_reg_we", {31'h0, reg_we_o}, 32'h0);
    chk("rst_stall_cnt", {28'h0, stall_cnt_o}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready_o}, 32'h1);

    // addi x1,x0,5 with one-cycle latency and drain
    ins = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
    drive(ins, 32'h100, 1'b0);
    q.push_back(mk(ins, 32'h100, 0, 0, 5, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    #1 chk("addi_in_ready", {31'h0, in_ready_o}, 32'h1);
    tick();
    chk("addi_latency", {31'h0, out_valid_o}, 32'h1);
    in_valid_i = 1'b0;
    tick();
    chk("drain_valid", {31'h0, out_valid_o}, 32'h0);

    // bypass priority and x0 handling
    fwd_valid_i = 2'b11; fwd_waddr_i = {5'd1, 5'd1}; fwd_wdata_i = {32'hBB, 32'hAA};
    ins = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    send(ins, 32'h104, 1'b0, mk(ins, 32'h104, 0, 32'hAA, 7, 0, 0, 32'hAA, 7, 1, 3, 0, 0, 0));
    fwd_valid_i = 2'b10;
    ins = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4);
    send(ins, 32'h108, 1'b0, mk(ins, 32'h108, 0, 32'hBB, 7, 0, 0, 32'hBB, 7, 1, 4, 0, 0, 0));
    fwd_valid_i = 2'b11; fwd_waddr_i = {5'd0, 5'd2}; fwd_wdata_i = {32'hDEAD, 32'h22};
    ins = enc_r(7'h00, 5'd2, 5'd0, 3'b000, 5'd5);
    send(ins, 32'h10C, 1'b0, mk(ins, 32'h10C, 0, 0, 32'h22, 0, 0, 0, 32'h22, 1, 5, 0, 0, 0));
    fwd_valid_i = 2'b00;
    in_valid_i = 1'b0;
    tick();

    // load-use hazard: three bubbles, then the load result arrives on channel 0
    ex_load_pending_i = 1'b1; ex_load_waddr_i = 5'd5;
    ins = enc_r(7'h00, 5'd5, 5'd5, 3'b000, 5'd6);
    drive(ins, 32'h110, 1'b0);
    q.push_back(mk(ins, 32'h110, 0, 32'h55, 32'h55, 0, 0, 32'h55, 32'h55, 1, 6, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      #1 chk("hazard_in_ready", {31'h0, in_ready_o}, 32'h0);
      tick();
      chk("hazard_bubble", {31'h0, out_valid_o}, 32'h0);
    end
    chk("stall_cnt_3", {28'h0, stall_cnt_o}, 32'd3);
    ex_load_pending_i = 1'b0;
    fwd_valid_i = 2'b01; fwd_waddr_i = {5'd0, 5'd5}; fwd_wdata_i = {32'h0, 32'h55};
    #1 chk("hazard_release", {31'h0, in_ready_o}, 32'h1);
    tick();
    fwd_valid_i = 2'b00;
    // pending load on an unused register does not stall
    ex_load_pending_i = 1'b1;
    ins = enc_i(12'd1, 5'd6, 3'b000, 5'd7, 7'b0010011);
    drive(ins, 32'h114, 1'b0);
    q.push_back(mk(ins, 32'h114, 0, 32'h1006, 1, 0, 0, 32'h1006, 0, 1, 7, 0, 0, 0));
    #1 chk("no_hazard_ready", {31'h0, in_ready_o}, 32'h1);
    tick();
    ex_load_pending_i = 1'b0;
    in_valid_i = 1'b0;
    tick();
    chk("stall_cnt_kept", {28'h0, stall_cnt_o}, 32'd3);

    // back-pressure hold for four cycles, then release
    out_ready_i = 1'b0;
    lui_i = {20'h12345, 5'd7, 7'b0110111};
    send(lui_i, 32'h118, 1'b0, mk(lui_i, 32'h118, 0, 32'h12345000, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0));
    ins = enc_i(12'd3, 5'd0, 3'b000, 5'd9, 7'b0010011);
    drive(ins, 32'h11C, 1'b0);
    q.push_back(mk(ins, 32'h11C, 0, 0, 3, 0, 0, 0, 0, 1, 9, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hold_valid", {31'h0, out_valid_o}, 32'h1);
      chk("hold_inst", inst_o, lui_i);
      chk("hold_op1", op1_o, 32'h12345000);
      chk("hold_waddr", {27'h0, reg_waddr_o}, 32'd7);
      chk("hold_in_ready", {31'h0, in_ready_o}, 32'h0);
      tick();
    end
    out_ready_i = 1'b1;
    #1 chk("release_in_ready", {31'h0, in_ready_o}, 32'h1);
    tick();
    in_valid_i = 1'b0;
    tick();

    // flush drops the held entry and discards the concurrent beat
    out_ready_i = 1'b0;
    ins = enc_i(12'd1, 5'd0, 3'b000, 5'd10, 7'b0010011);
    send(ins, 32'h120, 1'b0, mk(ins, 32'h120, 0, 0, 1, 0, 0, 0, 0, 1, 10, 0, 0, 0));
    drive(enc_i(12'd2, 5'd0, 3'b000, 5'd11, 7'b0010011), 32'h124, 1'b0);
    flush_i = 1'b1;
    #1 chk("flush_in_ready", {31'h0, in_ready_o}, 32'h1);
    tick();
    chk("flush_drop", {31'h0, out_valid_o}, 32'h0);
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    q.delete(0);
    out_ready_i = 1'b1;
    tick();
    chk("flush_discard", {31'h0, out_valid_o}, 32'h0);

    // decode corner cases
    ins = 32'hFFFF_FFFF;
    send(ins, 32'h200, 1'b0, mk(ins, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    ins = enc_r(7'h01, 5'd2, 5'd1, 3'b100, 5'd8);
    send(ins, 32'h204, 1'b0, mk(ins, 32'h204, 0, 32'h1001, 7, 32'h204, 4, 32'h1001, 7, 0, 8, 0, 0, 0));
    ins = enc_b(13'h1FF8, 5'd2, 5'd1, 3'b000);
    send(ins, 32'h208, 1'b1, mk(ins, 32'h208, 1, 32'h1001, 7, 32'h208, 4, 32'h1001, 7, 0, 0, 0, 0, 0));
    ins = enc_b(13'd16, 5'd2, 5'd1, 3'b001);
    send(ins, 32'h20C, 1'b0, mk(ins, 32'h20C, 0, 32'h1001, 7, 32'h20C, 16, 32'h1001, 7, 0, 0, 0, 0, 0));
    ins = enc_i(12'h300, 5'd1, 3'b001, 5'd12, 7'b1110011);
    send(ins, 32'h210, 1'b0, mk(ins, 32'h210, 0, 0, 0, 0, 0, 32'h1001, 0, 1, 12, 0, 1, 32'h300));
    ins = enc_i(12'd0, 5'd1, 3'b010, 5'd9, 7'b0001011);
`ifdef ID_CUSTOM_EXT_EN
    send(ins, 32'h214, 1'b0, mk(ins, 32'h214, 0, 32'h1001, 9, 0, 0, 32'h1001, 9, 1, 9, 0, 0, 0));
`else
    send(ins, 32'h214, 1'b0, mk(ins, 32'h214, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
`endif
    in_valid_i = 1'b0;
    tick();

    // reset while holding an entry
    out_ready_i = 1'b0;
    ins = enc_i(12'd7, 5'd0, 3'b000, 5'd13, 7'b0010011);
    send(ins, 32'h300, 1'b0, mk(ins, 32'h300, 0, 0, 7, 0, 0, 0, 0, 1, 13, 0, 0, 0));
    in_valid_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete(0);
    #1;
    chk("rst_hold_valid", {31'h0, out_valid_o}, 32'h0);
    chk("rst_hold_in_ready", {31'h0, in_ready_o}, 32'h1);
    out_ready_i = 1'b1;

    // stall counter saturation, then reset mid-stall
    ex_load_pending_i = 1'b1; ex_load_waddr_i = 5'd5;
    drive(enc_r(7'h00, 5'd5, 5'd5, 3'b000, 5'd6), 32'h400, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("stall_cnt_sat", {28'h0, stall_cnt_o}, 32'd15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_stall_cnt_clr", {28'h0, stall_cnt_o}, 32'h0);
    chk("rst_stall_inst", inst_o, 32'h1);
    chk("rst_stall_in_ready", {31'h0, in_ready_o}, 32'h0);
    ex_load_pending_i = 1'b0;
    in_valid_i = 1'b0;
    tick();
    chk("sb_empty", q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
